uart_rx_deframer: RTL and testbench

- Receive-side UART deframer that sits directly upstream of the MicroBlaze subsystem's byte input, consuming the raw serial line (uart_txd_in at board level).
- Recovers 8N1 frames using 16x oversampling and mid-bit sampling.
- Presents each received byte on a valid/ready handshake, with framing-error and overrun status for the processor-side UART registers.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_tick.sv | 26 ++
 rtl/uart_rx_deframer.sv | 157 +++++++++++++++
 tb/tb_uart_rx_deframer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, RX state encoding and baud divisor helper
package uart_pkg;

    localparam int DEF_CLK_FREQ   = 25000000;
    localparam int DEF_BAUD_RATE  = 115200;
    localparam int DEF_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } rx_state_t;

    // Rounded clk/(baud*os), floored at 2 so the divider always has a real count
    function automatic int tick_div(input int clk_freq, input int baud, input int os);
        int d;
        d = (clk_freq + (baud * os) / 2) / (baud * os);
        return (d < 2) ? 2 : d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - free-running divider producing a one-clock oversample tick
module uart_baud_tick #(
    parameter int DIV = 14
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int W = $clog2(DIV);

    logic [W-1:0] cnt;

    assign tick = (cnt == W'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_deframer.sv
// rtl/uart_rx_deframer.sv - 8N1 UART receive deframer with oversampled mid-bit sampling
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = DEF_CLK_FREQ,
    parameter int BAUD_RATE  = DEF_BAUD_RATE,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int NB_DATA    = 8
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic               i_rxd,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic               o_frame_err,
    output logic               o_overrun,
    output logic               o_busy
);

    localparam int TICK_DIV = tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int SCNT_W   = $clog2(OVERSAMPLE);
    localparam int BIDX_W   = $clog2(NB_DATA);

    localparam logic [SCNT_W-1:0] SCNT_MID  = SCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(OVERSAMPLE - 1);
    localparam logic [BIDX_W-1:0] BIT_LAST  = BIDX_W'(NB_DATA - 1);

    rx_state_t           state, state_next;
    logic                rx_meta, rxs;
    logic                tick;
    logic [SCNT_W-1:0]   scnt;
    logic [BIDX_W-1:0]   bit_idx;
    logic [NB_DATA-1:0]  shreg;
    logic                scnt_clr, shift_en, commit, fe_set;

    uart_baud_tick #(
        .DIV (TICK_DIV)
    ) u_tick (
        .clk   (clock),
        .rst_n (i_reset),
        .tick  (tick)
    );

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= i_rxd;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        scnt_clr   = 1'b0;
        shift_en   = 1'b0;
        commit     = 1'b0;
        fe_set     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rxs) begin
                    scnt_clr   = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                // Re-check the line at mid start bit; a high here was a glitch
                if (tick && scnt == SCNT_MID) begin
                    if (!rxs) begin
                        scnt_clr   = 1'b1;
                        state_next = ST_DATA;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (tick && scnt == SCNT_LAST) begin
                    shift_en = 1'b1;
                    if (bit_idx == BIT_LAST) begin
                        state_next = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (tick && scnt == SCNT_LAST) begin
                    commit     = rxs;
                    fe_set     = !rxs;
                    state_next = rxs ? ST_IDLE : ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (rxs) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            scnt    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (scnt_clr) begin
                scnt    <= '0;
                bit_idx <= '0;
            end else begin
                if (tick) begin
                    scnt <= scnt + 1'b1;
                end
                if (shift_en) begin
                    bit_idx <= bit_idx + 1'b1;
                end
            end
            if (shift_en) begin
                shreg <= {rxs, shreg[NB_DATA-1:1]};
            end
        end
    end

    // Holding register: a commit only lands if the slot is empty or being accepted now
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            if (commit) begin
                if (!o_valid || i_ready) begin
                    o_data  <= shreg;
                    o_valid <= 1'b1;
                end
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
            o_frame_err <= fe_set;
            o_overrun   <= commit && o_valid && !i_ready;
        end
    end

    assign o_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb/tb_uart_rx_deframer.sv - directed self-checking bench for uart_rx_deframer
module tb_uart_rx_deframer;

    localparam int BIT = 217;

    logic       clock = 1'b0;
    logic       i_reset = 1'b0;
    logic       i_rxd = 1'b1;
    logic       i_ready = 1'b0;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_overrun;
    logic       o_busy;

    int checks = 0;
    int failures = 0;

    logic [7:0] beats[$];
    int fe_cnt = 0;
    int ov_cnt = 0;
    int busy_cycles = 0;
    int rises = 0;
    int lat_bad = 0;
    logic prev_valid = 1'b0;
    logic prev_busy = 1'b0;

    uart_rx_deframer dut (
        .clock       (clock),
        .i_reset     (i_reset),
        .i_rxd       (i_rxd),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun),
        .o_busy      (o_busy)
    );

    always #20 clock = ~clock;

    always @(negedge clock) begin
        if (o_valid && i_ready) beats.push_back(o_data);
        if (o_frame_err) fe_cnt <= fe_cnt + 1;
        if (o_overrun) ov_cnt <= ov_cnt + 1;
        if (o_busy) busy_cycles <= busy_cycles + 1;
        if (o_valid && !prev_valid) begin
            rises <= rises + 1;
            if (!(prev_busy && !o_busy)) lat_bad <= lat_bad + 1;
        end
        prev_valid <= o_valid;
        prev_busy  <= o_busy;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        i_rxd = b;
        repeat (BIT) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    task automatic idle_bits(input int n);
        i_rxd = 1'b1;
        repeat (n * BIT) @(negedge clock);
    endtask

    initial begin
        int b0, fe0, ov0, r0, bc0;

        repeat (3) @(negedge clock);
        chk("rst_valid", o_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_data", o_data, 0);
        chk("rst_frame_err", o_frame_err, 0);
        chk("rst_overrun", o_overrun, 0);
        i_reset = 1'b1;

        idle_bits(10);
        chk("idle_busy_cycles", busy_cycles, 0);
        chk("idle_valid_rises", rises, 0);
        chk("idle_frame_err", fe_cnt, 0);
        chk("idle_overrun", ov_cnt, 0);

        i_ready = 1'b1;
        b0 = beats.size(); fe0 = fe_cnt; ov0 = ov_cnt;
        send_frame(8'h55, 1'b1);
        send_frame(8'hA3, 1'b1);
        idle_bits(2);
        chk("b2b_beats", beats.size() - b0, 2);
        chk("b2b_first", beats[b0], 8'h55);
        chk("b2b_second", beats[b0+1], 8'hA3);
        chk("b2b_frame_err", fe_cnt - fe0, 0);
        chk("b2b_overrun", ov_cnt - ov0, 0);
        chk("b2b_valid_latency", lat_bad, 0);

        i_ready = 1'b0;
        b0 = beats.size(); ov0 = ov_cnt; r0 = rises; fe0 = fe_cnt;
        send_frame(8'h3C, 1'b1);
        send_frame(8'hF0, 1'b1);
        idle_bits(2);
        chk("ovr_pulses", ov_cnt - ov0, 1);
        chk("ovr_valid_held", o_valid, 1);
        chk("ovr_data_held", o_data, 8'h3C);
        chk("ovr_rises", rises - r0, 1);
        i_ready = 1'b1;
        repeat (3) @(negedge clock);
        chk("ovr_accept_count", beats.size() - b0, 1);
        chk("ovr_accept_data", beats[b0], 8'h3C);
        chk("ovr_valid_cleared", o_valid, 0);
        idle_bits(12);
        chk("ovr_no_second_beat", rises - r0, 1);
        chk("ovr_frame_err", fe_cnt - fe0, 0);

        bc0 = busy_cycles; r0 = rises; fe0 = fe_cnt;
        i_rxd = 1'b0;
        repeat (42) @(negedge clock);
        idle_bits(2);
        chk("glitch_busy_range", (busy_cycles - bc0 >= 96) && (busy_cycles - bc0 <= 116), 1);
        chk("glitch_no_valid", rises - r0, 0);
        chk("glitch_no_frame_err", fe_cnt - fe0, 0);

        b0 = beats.size(); fe0 = fe_cnt; ov0 = ov_cnt;
        send_frame(8'h81, 1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        idle_bits(2);
        chk("brk_frame_err", fe_cnt - fe0, 1);
        chk("brk_no_byte", beats.size() - b0, 0);
        send_frame(8'h42, 1'b1);
        idle_bits(2);
        chk("brk_after_count", beats.size() - b0, 1);
        chk("brk_after_data", beats[b0], 8'h42);
        chk("brk_overrun", ov_cnt - ov0, 0);

        b0 = beats.size(); fe0 = fe_cnt;
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        i_reset = 1'b0;
        #1;
        chk("mid_rst_busy", o_busy, 0);
        chk("mid_rst_valid", o_valid, 0);
        chk("mid_rst_data", o_data, 0);
        repeat (3) @(negedge clock);
        i_rxd = 1'b1;
        i_reset = 1'b1;
        idle_bits(1);
        send_frame(8'h19, 1'b1);
        idle_bits(2);
        chk("mid_rst_after_count", beats.size() - b0, 1);
        chk("mid_rst_after_data", beats[b0], 8'h19);
        chk("mid_rst_frame_err", fe_cnt - fe0, 0);
        chk("final_valid_latency", lat_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
